// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha block scheduler.
//   word_t          : 32-bit state word
//   SIGMA0..SIGMA3  : "expand 32-byte k" constants (state words 0-3)
//   state_t         : scheduler FSM states
//   QR_A..QR_D      : state-word indices of the a/b/c/d operands for each of
//                     the eight quarter rounds of a double round
//   rotl            : 32-bit rotate left
package chacha_pkg;

  typedef logic [31:0] word_t;

  localparam word_t SIGMA0 = 32'h6170_7865;
  localparam word_t SIGMA1 = 32'h3320_646e;
  localparam word_t SIGMA2 = 32'h7962_2d32;
  localparam word_t SIGMA3 = 32'h6b20_6574;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    ADD,
    OUT,
    FIN
  } state_t;

  // Entries 0-3 are the column rounds, entries 4-7 the diagonal rounds.
  localparam logic [3:0] QR_A [8] = '{4'd0,  4'd1,  4'd2,  4'd3,  4'd0,  4'd1,  4'd2,  4'd3};
  localparam logic [3:0] QR_B [8] = '{4'd4,  4'd5,  4'd6,  4'd7,  4'd5,  4'd6,  4'd7,  4'd4};
  localparam logic [3:0] QR_C [8] = '{4'd8,  4'd9,  4'd10, 4'd11, 4'd10, 4'd11, 4'd8,  4'd9};
  localparam logic [3:0] QR_D [8] = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd12, 4'd13, 4'd14};

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_block_sched_if.sv
// Request/keystream bus of the ChaCha block scheduler.
//   master : requester/consumer side (drives start, key, nonce, ctr_init,
//            nblocks, ks_ready; observes busy, ks_valid, ks_block, ks_index,
//            done)
//   slave  : scheduler side
// Optional: CHACHA_CTR_WRAP_ERR_EN adds ctr_err (scheduler -> master).
interface chacha_block_sched_if;

  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr_init;
  logic [7:0]   nblocks;
  logic         busy;
  logic         ks_valid;
  logic         ks_ready;
  logic [511:0] ks_block;
  logic [7:0]   ks_index;
  logic         done;
`ifdef CHACHA_CTR_WRAP_ERR_EN
  logic         ctr_err;
`endif

  modport master (
    output start, key, nonce, ctr_init, nblocks, ks_ready,
    input  busy, ks_valid, ks_block, ks_index, done
`ifdef CHACHA_CTR_WRAP_ERR_EN
    , input ctr_err
`endif
  );

  modport slave (
    input  start, key, nonce, ctr_init, nblocks, ks_ready,
    output busy, ks_valid, ks_block, ks_index, done
`ifdef CHACHA_CTR_WRAP_ERR_EN
    , output ctr_err
`endif
  );

endinterface

// File: rtl/chacha_qround.sv
// Combinational ChaCha quarter round.
//   a_in..d_in   : operand words
//   a_out..d_out : quarter-round results (all arithmetic modulo 2^32)
module chacha_qround
  import chacha_pkg::*;
(
  input  word_t a_in,
  input  word_t b_in,
  input  word_t c_in,
  input  word_t d_in,
  output word_t a_out,
  output word_t b_out,
  output word_t c_out,
  output word_t d_out
);

  word_t a1, b1, c1, d1;

  assign a1    = a_in + b_in;
  assign d1    = rotl(d_in ^ a1, 16);
  assign c1    = c_in + d1;
  assign b1    = rotl(b_in ^ c1, 12);
  assign a_out = a1 + b1;
  assign d_out = rotl(d1 ^ a_out, 8);
  assign c_out = c1 + d_out;
  assign b_out = rotl(b1 ^ c_out, 7);

endmodule

// File: rtl/chacha_block_sched.sv
// ChaCha keystream block scheduler: produces nblocks consecutive keystream
// blocks from a captured key/nonce/counter, one quarter round per cycle,
// with a valid/ready handshake per block.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : chacha_block_sched_if.slave (request inputs, keystream
//              output handshake, busy/done status)
//   DR_COUNT : double rounds per block
// Optional: CHACHA_CTR_WRAP_ERR_EN stops the run with ctr_err instead of
// letting the block counter wrap past 0xFFFFFFFF.
module chacha_block_sched
  import chacha_pkg::*;
#(
  parameter int DR_COUNT = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  chacha_block_sched_if.slave     bus
);

  localparam int NROUNDS = 8 * DR_COUNT;
  localparam int RW      = $clog2(NROUNDS + 1);

  state_t        state, state_next;
  word_t         x    [16];   // working state
  word_t         init [16];   // initial-state copy for the final add
  word_t         seed [16];
  logic [255:0]  key_r;
  logic [95:0]   nonce_r;
  word_t         ctr;
  logic [7:0]    nblocks_r;
  logic [7:0]    idx;
  logic [511:0]  blk;
  logic [RW-1:0] rnd;
  logic [2:0]    sel;
  logic          hs, last, wrap_stop, err;
  word_t         qa, qb, qc, qd;

  assign sel  = rnd[2:0];
  assign hs   = (state == OUT) && bus.ks_ready;
  assign last = ({1'b0, idx} + 9'd1) == {1'b0, nblocks_r};

`ifdef CHACHA_CTR_WRAP_ERR_EN
  assign wrap_stop   = (ctr == 32'hFFFF_FFFF);
  assign bus.ctr_err = (state == FIN) && err;
`else
  assign wrap_stop = 1'b0;
`endif

  always_comb begin
    seed[0] = SIGMA0;
    seed[1] = SIGMA1;
    seed[2] = SIGMA2;
    seed[3] = SIGMA3;
    for (int j = 0; j < 8; j++) seed[4 + j] = key_r[32*j +: 32];
    seed[12] = ctr;
    for (int k = 0; k < 3; k++) seed[13 + k] = nonce_r[32*k +: 32];
  end

  chacha_qround u_qround (
    .a_in  (x[QR_A[sel]]),
    .b_in  (x[QR_B[sel]]),
    .c_in  (x[QR_C[sel]]),
    .d_in  (x[QR_D[sel]]),
    .a_out (qa),
    .b_out (qb),
    .c_out (qc),
    .d_out (qd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets its default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = (bus.nblocks != 8'd0) ? LOAD : FIN;
      LOAD:    state_next = ROUND;
      ROUND:   if (rnd == RW'(NROUNDS - 1)) state_next = ADD;
      ADD:     state_next = OUT;
      OUT:     if (hs) state_next = (last || wrap_stop) ? FIN : LOAD;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state arrays are cleared by the reset like any other register, so
  // no key material or keystream survives a reset; sequential updates use
  // non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        x[i]    <= '0;
        init[i] <= '0;
      end
      key_r     <= '0;
      nonce_r   <= '0;
      ctr       <= '0;
      nblocks_r <= '0;
      idx       <= '0;
      blk       <= '0;
      rnd       <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          key_r     <= bus.key;
          nonce_r   <= bus.nonce;
          ctr       <= bus.ctr_init;
          nblocks_r <= bus.nblocks;
          idx       <= '0;
          err       <= 1'b0;
        end
        LOAD: begin
          for (int i = 0; i < 16; i++) begin
            x[i]    <= seed[i];
            init[i] <= seed[i];
          end
          rnd <= '0;
        end
        ROUND: begin
          x[QR_A[sel]] <= qa;
          x[QR_B[sel]] <= qb;
          x[QR_C[sel]] <= qc;
          x[QR_D[sel]] <= qd;
          rnd          <= rnd + 1'b1;
        end
        ADD:
          for (int i = 0; i < 16; i++) blk[32*i +: 32] <= x[i] + init[i];
        OUT: if (hs && !last) begin
          // A counter about to wrap ends the run (error build only).
          if (wrap_stop) begin
            err <= 1'b1;
          end else begin
            ctr <= ctr + 32'd1;
            idx <= idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.ks_valid = (state == OUT);
  assign bus.ks_block = blk;
  assign bus.ks_index = idx;
  assign bus.done     = (state == FIN);

endmodule

// File: tb/tb_chacha_block_sched.sv
module tb_chacha_block_sched;
  import chacha_pkg::*;

`ifdef CHACHA_CTR_WRAP_ERR_EN
  localparam bit WRAP_ERR = 1'b1;
`else
  localparam bit WRAP_ERR = 1'b0;
`endif
  localparam int LATENCY = 8 * 10 + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chacha_block_sched_if bus ();

  chacha_block_sched #(.DR_COUNT(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic [7:0]   nb;
    int           stall;
    bit           poke;
    bit           rfc;
    int           exp_blocks;
    bit           exp_err;
  } vec_t;

  vec_t vecs [5];
  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic void qr(inout logic [31:0] a, inout logic [31:0] b,
                             inout logic [31:0] c, inout logic [31:0] d);
    a += b; d ^= a; d = rl(d, 16);
    c += d; b ^= c; b = rl(b, 12);
    a += b; d ^= a; d = rl(d, 8);
    c += d; b ^= c; b = rl(b, 7);
  endfunction

  // Reference ChaCha block function, written directly from the algorithm.
  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    logic [31:0]  s [16];
    logic [31:0]  w [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s[4 + j] = k[32*j +: 32];
    s[12] = c;
    for (int m = 0; m < 3; m++) s[13 + m] = n[32*m +: 32];
    w = s;
    for (int dr = 0; dr < 10; dr++) begin
      qr(w[0], w[4], w[8],  w[12]);
      qr(w[1], w[5], w[9],  w[13]);
      qr(w[2], w[6], w[10], w[14]);
      qr(w[3], w[7], w[11], w[15]);
      qr(w[0], w[5], w[10], w[15]);
      qr(w[1], w[6], w[11], w[12]);
      qr(w[2], w[7], w[8],  w[13]);
      qr(w[3], w[4], w[9],  w[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + s[i];
    return r;
  endfunction

  // Number of blocks a run yields and whether it ends on a counter wrap.
  function automatic int blocks_of(input logic [31:0] c, input logic [7:0] nb, output bit err);
    err = 1'b0;
    for (int i = 0; i < int'(nb); i++) begin
      if (WRAP_ERR && (c + 32'(i)) == 32'hFFFF_FFFF && i < int'(nb) - 1) begin
        err = 1'b1;
        return i + 1;
      end
    end
    return int'(nb);
  endfunction

  task automatic do_run(input vec_t v);
    int          cyc;
    logic [511:0] exp;
    check("idle_busy", bus.busy, 1'b0);
    bus.key      = v.key;
    bus.nonce    = v.nonce;
    bus.ctr_init = v.ctr;
    bus.nblocks  = v.nb;
    bus.ks_ready = (v.stall == 0);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (v.exp_blocks == 0) begin
      check("nb0_done", bus.done, 1'b1);
      check("nb0_valid", bus.ks_valid, 1'b0);
      @(posedge clk); #1;
      check("nb0_idle", {bus.busy, bus.done, bus.ks_valid}, 3'b000);
      return;
    end
    for (int b = 0; b < v.exp_blocks; b++) begin
      cyc = 0;
      while (!bus.ks_valid && cyc < 200) begin
        if (v.poke && b == 0 && cyc == 30) begin
          // A new request while busy must be ignored.
          bus.start   = 1'b1;
          bus.key     = ~v.key;
          bus.nblocks = 8'd0;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
      bus.start = 1'b0;
      check("ks_valid_latency", cyc, LATENCY);
      if (!bus.ks_valid) return;
      exp = ref_block(v.key, v.nonce, v.ctr + 32'(b));
      check("ks_block", bus.ks_block, exp);
      check("ks_index", bus.ks_index, 8'(b));
      check("busy_in_out", {bus.busy, bus.done}, 2'b10);
      if (v.rfc && b == 0) begin
        check("rfc_word0", bus.ks_block[31:0], 32'he4e7f110);
        check("rfc_word15", bus.ks_block[511:480], 32'h4e3c50a2);
      end
      for (int s = 0; s < v.stall; s++) begin
        @(posedge clk); #1;
        check("stall_valid", bus.ks_valid, 1'b1);
        check("stall_block", bus.ks_block, exp);
        check("stall_index", bus.ks_index, 8'(b));
      end
      bus.ks_ready = 1'b1;
      @(posedge clk); #1;
      if (v.stall > 0) bus.ks_ready = 1'b0;
      if (b < v.exp_blocks - 1) begin
        check("valid_drop", bus.ks_valid, 1'b0);
        check("no_early_done", bus.done, 1'b0);
      end
    end
    check("done_pulse", {bus.done, bus.ks_valid}, 2'b10);
`ifdef CHACHA_CTR_WRAP_ERR_EN
    check("ctr_err", bus.ctr_err, v.exp_err);
`endif
    @(posedge clk); #1;
    check("done_end", {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin
    vec_t rv;
    bit   e;
    int   cyc;

    for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
    rfc_nonce = {32'h0000_0000, 32'h4a00_0000, 32'h0900_0000};

    vecs[0] = '{rfc_key, rfc_nonce, 32'd1, 8'd1, 0, 1'b0, 1'b1, 1, 1'b0};
    vecs[1] = '{rfc_key, rfc_nonce, 32'd1, 8'd3, 10, 1'b0, 1'b1, 3, 1'b0};
    vecs[2] = '{rfc_key, rfc_nonce, 32'd5, 8'd0, 0, 1'b0, 1'b0, 0, 1'b0};
    vecs[3] = '{~rfc_key, ~rfc_nonce, 32'hFFFF_FFFF, 8'd2, 2, 1'b0, 1'b0,
                (WRAP_ERR ? 1 : 2), WRAP_ERR};
    vecs[4] = '{rfc_key, rfc_nonce, 32'd1, 8'd1, 0, 1'b1, 1'b1, 1, 1'b0};

    bus.start = 1'b0; bus.key = '0; bus.nonce = '0; bus.ctr_init = '0;
    bus.nblocks = '0; bus.ks_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_outputs", {bus.busy, bus.ks_valid, bus.done, bus.ks_index, bus.ks_block}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) do_run(vecs[t]);

    // Reset in the middle of ROUND (round cycle 40).
    bus.key = rfc_key; bus.nonce = rfc_nonce; bus.ctr_init = 32'd1;
    bus.nblocks = 8'd1; bus.ks_ready = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (41) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun_reset", {bus.busy, bus.ks_valid, bus.done, bus.ks_index, bus.ks_block}, '0);
`ifdef CHACHA_CTR_WRAP_ERR_EN
    check("midrun_reset_err", bus.ctr_err, 1'b0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    do_run(vecs[0]);

    // Randomized runs against the reference model.
    for (int r = 0; r < 6; r++) begin
      rv.key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rv.nonce = {$urandom, $urandom, $urandom};
      rv.ctr   = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFE : 32'($urandom);
      rv.nb    = 8'($urandom_range(1, 3));
      rv.stall = $urandom_range(0, 3);
      rv.poke  = 1'($urandom_range(0, 1));
      rv.rfc   = 1'b0;
      rv.exp_blocks = blocks_of(rv.ctr, rv.nb, e);
      rv.exp_err    = e;
      do_run(rv);
    end

    // Idle settle: nothing should appear without a request.
    cyc = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.busy || bus.ks_valid || bus.done) cyc++;
    end
    check("idle_quiet", cyc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
